ahb3lite_rv_mem_responder: RTL

AHB3LITE_RV_MEM_RESPONDER -- requirements
Module: ahb3lite_rv_mem_responder

---
 rtl/ahb3lite_rv_mem_responder.sv | 160 ++++++++++++++++
 1 files changed

// File: rtl/ahb3lite_rv_mem_responder.sv
// AHB3-Lite word-addressed memory responder with RV32I-NOP reset contents,
// configurable data-phase wait states, two-cycle ERROR response and a
// side-band preload port.
module ahb3lite_rv_mem_responder #(
    parameter logic [31:0] BASE        = 32'h0000_0000,
    parameter int          DEPTH       = 16,
    parameter int          WAIT_STATES = 0
) (
    input  logic                     HCLK,
    input  logic                     HRESETn,
    input  logic                     HSEL,
    input  logic [31:0]              HADDR,
    input  logic                     HWRITE,
    input  logic [2:0]               HSIZE,
    input  logic [1:0]               HTRANS,
    input  logic [31:0]              HWDATA,
    input  logic                     HREADY,
    output logic [31:0]              HRDATA,
    output logic                     HREADYOUT,
    output logic                     HRESP,
    input  logic                     ld_we,
    input  logic [$clog2(DEPTH)-1:0] ld_idx,
    input  logic [31:0]              ld_data
);

    localparam int          IW   = $clog2(DEPTH);
    localparam logic [31:0] SPAN = 32'(DEPTH * 4);
    localparam logic [2:0]  WS   = 3'(WAIT_STATES);
    localparam logic [31:0] NOP  = 32'h0000_0013;

    localparam logic [1:0] ST_OK   = 2'd0;
    localparam logic [1:0] ST_WAIT = 2'd1;
    localparam logic [1:0] ST_ERR1 = 2'd2;
    localparam logic [1:0] ST_ERR2 = 2'd3;

    // Byte-lane enables for a write of the given size at the given byte offset.
    function automatic logic [3:0] lane_mask(input logic [1:0] size, input logic [1:0] lo);
        logic [3:0] m;
        case (size)
            2'b00:   m = 4'b0001 << lo;
            2'b01:   m = lo[1] ? 4'b1100 : 4'b0011;
            2'b10:   m = 4'b1111;
            default: m = 4'b0000;
        endcase
        return m;
    endfunction

    logic [1:0]    state_r;
    logic [2:0]    cnt_r;
    logic          valid_r;
    logic          write_r;
    logic [1:0]    size_r;
    logic [1:0]    lo_r;
    logic [IW-1:0] idx_r;
    logic [31:0]   mem_r [DEPTH];

    logic [31:0] offset_s;
    logic        bad_s;
    logic        ready_s;
    logic        accept_s;
    logic        complete_s;
    logic        commit_s;
    logic [3:0]  mask_s;
    logic [1:0]  state_nxt_s;
    logic [2:0]  cnt_nxt_s;
    logic        unused_s;

    assign unused_s = HTRANS[0];

    // Address-phase decode: offset from BASE (wrapping), error rules, handshake.
    always_comb begin
        offset_s   = HADDR - BASE;
        bad_s      = (offset_s >= SPAN) ||
                     (HSIZE > 3'b010) ||
                     ((HSIZE == 3'b001) && HADDR[0]) ||
                     ((HSIZE == 3'b010) && (HADDR[1:0] != 2'b00));
        ready_s    = (state_r == ST_OK) || (state_r == ST_ERR2) ||
                     ((state_r == ST_WAIT) && (cnt_r == 3'd0));
        accept_s   = HSEL && HTRANS[1] && HREADY && ready_s;
        complete_s = valid_r && ((state_r == ST_OK) ||
                                 ((state_r == ST_WAIT) && (cnt_r == 3'd0)));
        commit_s   = complete_s && write_r;
        mask_s     = lane_mask(size_r, lo_r);
    end

    // Next FSM state and wait-state down-counter.
    always_comb begin
        state_nxt_s = state_r;
        cnt_nxt_s   = cnt_r;
        if (ready_s) begin
            if (accept_s && bad_s) begin
                state_nxt_s = ST_ERR1;
                cnt_nxt_s   = 3'd0;
            end else if (accept_s && (WS != 3'd0)) begin
                state_nxt_s = ST_WAIT;
                cnt_nxt_s   = WS;
            end else begin
                state_nxt_s = ST_OK;
                cnt_nxt_s   = 3'd0;
            end
        end else begin
            case (state_r)
                ST_WAIT: cnt_nxt_s   = cnt_r - 3'd1;
                ST_ERR1: state_nxt_s = ST_ERR2;
                default: state_nxt_s = ST_OK;
            endcase
        end
    end

    // FSM state plus the registered address-phase controls of the pending transfer.
    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            state_r <= ST_OK;
            cnt_r   <= 3'd0;
            valid_r <= 1'b0;
            write_r <= 1'b0;
            size_r  <= 2'b00;
            lo_r    <= 2'b00;
            idx_r   <= '0;
        end else begin
            state_r <= state_nxt_s;
            cnt_r   <= cnt_nxt_s;
            if (ready_s) begin
                valid_r <= accept_s && !bad_s;
                if (accept_s) begin
                    write_r <= HWRITE;
                    size_r  <= HSIZE[1:0];
                    lo_r    <= HADDR[1:0];
                    idx_r   <= offset_s[IW+1:2];
                end
            end
        end
    end

    // Memory array: NOP fill on reset, preload wins over a same-edge bus write.
    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_r[i] <= NOP;
            end
        end else begin
            for (int i = 0; i < DEPTH; i++) begin
                if (ld_we && (ld_idx == IW'(i))) begin
                    mem_r[i] <= ld_data;
                end else if (commit_s && (idx_r == IW'(i))) begin
                    for (int b = 0; b < 4; b++) begin
                        if (mask_s[b]) begin
                            mem_r[i][8*b +: 8] <= HWDATA[8*b +: 8];
                        end
                    end
                end
            end
        end
    end

    assign HREADYOUT = ready_s;
    assign HRESP     = (state_r == ST_ERR1) || (state_r == ST_ERR2);
    assign HRDATA    = (complete_s && !write_r) ? mem_r[idx_r] : 32'h0000_0000;

endmodule
